imem_responder: RTL
===================

# imem_responder

Instruction-memory responder that answers the fetch unit's instruction bus (imem_addr / imem_addr_valid in, imem_data / imem_data_valid out). It serves 64-bit big-endian instruction windows from an on-chip synchronous RAM, merging two consecutive words when a fetch is not 8-byte aligned. It sits between the core's fetch port and program memory. A side load port fills the RAM at boot.

## Interface
- DEPTH_LOG2, 12: log2 of RAM depth in 64-bit words (default 32 KiB).
- BASE_ADDR, 64'h0: byte address of RAM word 0.
- WAIT_STATES, 0: extra cycles inserted per RAM read (0–15), models slow memory.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- imem_addr  in  64  byte fetch address; bit 0 ignored.
- imem_addr_valid  in  1  request; initiator holds it and imem_addr stable until imem_data_valid.
- imem_data  out  64  instruction window; bits [63:48] come from the lowest address.
- imem_data_valid  out  1  one-cycle completion pulse.
- imem_fault  out  1  qualifies imem_data_valid; the address was out of range.
- load_we  in  1  RAM write strobe.
- load_addr  in  DEPTH_LOG2  RAM word index.
- load_data  in  64  RAM write data.

## Operation
- Registered FSM states: IDLE, RD0, RD1, RESP.
- IDLE:
  - On imem_addr_valid, latch the address. Compute offset = addr - BASE_ADDR and word index N = offset[DEPTH_LOG2+2:3].
  - Issue a RAM read of N in the same cycle (RAM address is combinational from imem_addr in IDLE). Go to RD0.
- RD0:
  - Wait WAIT_STATES cycles using the counter, then capture RAM data into lo.
  - If addr[2:1]==0: form output = lo, go to RESP.
  - Otherwise: issue a read of N+1, go to RD1.
- RD1: wait WAIT_STATES cycles, then capture RAM data into hi.
  - Output = upper 64 bits of ({lo,hi} << (16*addr[2:1])).
  - Go to RESP.
- RESP: imem_data_valid=1 for exactly this cycle, then IDLE.
  - The first cycle back in IDLE samples imem_addr_valid again, so back-to-back requests are legal.
- Range check, evaluated at request time:
  - offset ≥ 8·2^DEPTH_LOG2 or address below BASE_ADDR → no RAM read; data=0, fault=1.
  - An unaligned fetch whose N+1 runs past the top word → same fault behaviour.
  - In both cases the response arrives with the aligned latency.
- Load port:
  - Writes in any state, one word per cycle.
  - A same-cycle read of the same word returns the old data (read-first).
- Outputs are registered. imem_data holds its last value between pulses. imem_fault is meaningful only when imem_data_valid=1 and is otherwise 0.
- Address changes while a request is in flight are a protocol violation. The latched address is used.

## Timing
- Reset (asynchronous, any state including mid-request):
  - State → IDLE, imem_data_valid=0, imem_data=0, imem_fault=0, counter=0, lo/hi=0.
  - RAM contents are preserved. Any in-flight request is dropped and no response is produced.
- Latency is measured from the request cycle T (IDLE with imem_addr_valid=1) to the imem_data_valid cycle:
  - aligned: T+2+WAIT_STATES;
  - unaligned: T+3+2·WAIT_STATES;
  - fault: T+2+WAIT_STATES.
- Throughput, WAIT_STATES=0: one aligned fetch per 3 cycles, one unaligned fetch per 4 cycles.
- The wait counter is 4 bits and reloads on every RAM read issue.

## Configuration
- IMEM_UNALIGNED_EN defined: two-read merge as above.
- IMEM_UNALIGNED_EN undefined:
  - The RD1 state, the hi register and the shifter are removed.
  - addr[2:0] is ignored for data and the aligned word N is returned.
  - If addr[2:1]≠0, imem_fault=1 is returned with that data.
  - All fetches use aligned latency.

## Structure
- Shared header imem_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, RD0=2'd1, RD1=2'd2, RESP=2'd3);
  - IMEM_WORD_BYTES=8;
  - parcel width 16.
- Sub-module imem_ram:
  - Single-clock, one synchronous read port, one write port, read-first, 64×2^DEPTH_LOG2.
  - No reset on the array.

## Test plan
- Load word 0=64'h0011_2233_4455_6677 and word 1=64'h8899_AABB_CCDD_EEFF. Request addr 0x0 → imem_data_valid at T+2, data 0011_2233_4455_6677, fault 0.
- With the same contents, request addr 0x4 (macro defined) → valid at T+3, data 4455_6677_8899_AABB. Repeat with WAIT_STATES=2 → valid at T+7.
- Request addr 8·2^DEPTH_LOG2 (one byte-word past the top) → valid at T+2, data 0, fault 1. Request the top word +6 unaligned → fault 1.
- Hold imem_addr_valid high across responses with addresses 0x0, 0x8, 0x10 → three pulses, 3 cycles apart, each with the correct word.
- Assert rst_n=0 in RD1 of an unaligned fetch → outputs 0 immediately, no pulse after release. A subsequent request to 0x0 returns the loaded word.
- Load-write word 0=64'hDEAD_BEEF_0000_0001 in the same cycle as a request to 0x0 → response is the old word. The next request returns the new word.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM state encodings,
// bus geometry and the unaligned window merge helper.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd0  = 2'd1,
    StRd1  = 2'd2,
    StResp = 2'd3
  } imem_state_e;

  localparam int unsigned IMEM_WORD_BYTES = 8;
  localparam int unsigned IMEM_PARCEL_W   = 16;

  // Big-endian window starting sh parcels into lo, continuing into hi.
  function automatic logic [63:0] imem_merge(input logic [63:0] lo, input logic [63:0] hi,
                                             input logic [1:0] sh);
    logic [127:0] win;
    win = {lo, hi} << (IMEM_PARCEL_W * 32'(sh));
    return win[127:64];
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Program RAM: one synchronous read port and one write port on a single clock.
// Read-first: a read and a write of the same word in one cycle return the old data.
// The array has no reset so boot-loaded contents survive a core reset.
module imem_ram #(
  parameter int unsigned AddrW = 12
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [63:0]      wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem [2**AddrW];
  logic [63:0] rdata_q;

  // Read data only changes on a read strobe so it stays stable across wait states.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves 64-bit big-endian fetch windows from on-chip RAM.
// Optional feature macro IMEM_UNALIGNED_EN: when defined, fetches that are not 8-byte
// aligned merge two consecutive words; when undefined they return the aligned word
// with imem_fault set.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           imem_addr,
  input  logic                  imem_addr_valid,
  output logic [63:0]           imem_data,
  output logic                  imem_data_valid,
  output logic                  imem_fault,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [63:0]           load_data
);

  localparam logic [63:0] RangeBytes = 64'(IMEM_WORD_BYTES) << DEPTH_LOG2;
  localparam logic [3:0]  WaitCnt    = 4'(WAIT_STATES);

  imem_state_e           state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  oor_q;
  logic [3:0]            cnt_q, cnt_d;
  logic [63:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;

  logic [63:0]           offset;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_oor;
  logic                  req_take;

  logic                  ram_re;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [63:0]           ram_rdata;

`ifdef IMEM_UNALIGNED_EN
  logic [1:0]  sh_q;
  logic [63:0] lo_q, lo_d;
`else
  logic        mis_q;
  logic        req_mis;
`endif

  assign req_take = (state_q == StIdle) && imem_addr_valid;

  // Request decode; any out-of-range fetch skips the RAM and answers with data 0.
  always_comb begin
    offset  = imem_addr - BASE_ADDR;
    req_idx = offset[DEPTH_LOG2+2:3];
    req_oor = (imem_addr < BASE_ADDR) || (offset >= RangeBytes);
`ifdef IMEM_UNALIGNED_EN
    // The second word of an unaligned window must also exist.
    if ((imem_addr[2:1] != 2'b00) && (req_idx == '1)) begin
      req_oor = 1'b1;
    end
`else
    req_mis = (imem_addr[2:1] != 2'b00);
`endif
  end

  imem_ram #(
    .AddrW (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (load_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (imem_addr_valid) begin
          state_d = StRd0;
        end
      end
      StRd0: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
`ifdef IMEM_UNALIGNED_EN
          if (!oor_q && (sh_q != 2'b00)) begin
            state_d = StRd1;
          end
`endif
        end
      end
      StRd1: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RAM control, wait counter and next values of the registered outputs.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = req_idx;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    fault_d   = 1'b0;
`ifdef IMEM_UNALIGNED_EN
    lo_d      = lo_q;
`endif
    case (state_q)
      StIdle: begin
        if (imem_addr_valid) begin
          ram_re = !req_oor;
          cnt_d  = WaitCnt;
        end
      end
      StRd0: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (oor_q) begin
          data_d  = '0;
          valid_d = 1'b1;
          fault_d = 1'b1;
`ifdef IMEM_UNALIGNED_EN
        end else if (sh_q != 2'b00) begin
          lo_d      = ram_rdata;
          ram_re    = 1'b1;
          ram_raddr = idx_q + DEPTH_LOG2'(1);
          cnt_d     = WaitCnt;
        end else begin
          data_d  = ram_rdata;
          valid_d = 1'b1;
        end
`else
        end else begin
          data_d  = ram_rdata;
          valid_d = 1'b1;
          fault_d = mis_q;
        end
`endif
      end
      StRd1: begin
`ifdef IMEM_UNALIGNED_EN
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = imem_merge(lo_q, ram_rdata, sh_q);
          valid_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers: latched request, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef IMEM_UNALIGNED_EN
      sh_q    <= 2'b00;
      lo_q    <= '0;
`else
      mis_q   <= 1'b0;
`endif
    end else begin
      if (req_take) begin
        idx_q <= req_idx;
        oor_q <= req_oor;
`ifdef IMEM_UNALIGNED_EN
        sh_q  <= imem_addr[2:1];
`else
        mis_q <= req_mis;
`endif
      end
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
`ifdef IMEM_UNALIGNED_EN
      lo_q    <= lo_d;
`endif
    end
  end

  assign imem_data       = data_q;
  assign imem_data_valid = valid_q;
  assign imem_fault      = fault_q;

endmodule
